coeff_frame_assembler: RTL and testbench
========================================

Name: coeff_frame_assembler

Overview:
- Upstream of the coefficient-extraction stage.
- Consumes the byte stream from the SPI byte receiver and hunts for the 0xAA55 sync word.
- Collects the following 40 payload bytes (5 ADC words, 15 coefficients) and presents a complete 336-bit frame to the extractor.
- The output frame is double-buffered: the extractor only ever sees complete, sync-validated frames.

Parameters:
- PAYLOAD_BYTES, 40, bytes collected after the sync word; output width = 16 + 8*PAYLOAD_BYTES.
- SYNC_WORD, 16'hAA55, two-byte frame marker, high byte first.
- TIMEOUT_CYCLES, 48000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_byte  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- cs_abort  input  1  SPI chip-select deasserted; aborts any frame in progress
- frame_out  output  336  last committed frame, [335:320]=SYNC_WORD
- frame_valid  output  1  one-cycle pulse when frame_out updates
- frame_err  output  1  one-cycle pulse on timeout or abort with partial payload
- busy  output  1  high in SYNC_LO or COLLECT

Behaviour:
- Clock and reset
  - One clock; reset is synchronous and active-high.
  - Reset: state=HUNT_HI, byte_idx=0, idle_cnt=0, frame_valid=0, frame_err=0, busy=0.
  - frame_out resets to DEFAULT_FRAME: SYNC_WORD, 80 zero bits, then per band {16'h4000, 64'h0}, i.e. unity pass-through. This default is always present, so the extractor's outputs are defined from reset.
  - Reset mid-frame discards the shadow contents; frame_out returns to DEFAULT_FRAME.
- States
  - HUNT_HI: on rx_valid with rx_byte==SYNC_WORD[15:8], go to SYNC_LO. Other bytes are ignored.
  - SYNC_LO:
    - rx_byte==SYNC_WORD[7:0]: go to COLLECT, byte_idx=0.
    - rx_byte==SYNC_WORD[15:8]: stay in SYNC_LO.
    - Any other byte: go to HUNT_HI (no frame_err).
  - COLLECT:
    - Each rx_valid writes rx_byte into shadow[319-8*byte_idx -: 8]. First payload byte lands in the MSB; payload bytes are not sync-checked.
    - When byte_idx==PAYLOAD_BYTES-1 and rx_valid=1, on that same edge: frame_out <= {SYNC_WORD, shadow[319:8], rx_byte}; frame_valid <= 1; state goes to HUNT_HI.
    - frame_out and frame_valid become visible the cycle after the last byte strobe. Latency is 1 cycle.
- Timing
  - frame_valid and frame_err are single-cycle pulses.
  - Back-to-back frames are supported: a sync byte arriving in the cycle after commit is accepted.
- Timeout
  - idle_cnt increments each cycle in SYNC_LO or COLLECT without rx_valid, and clears on rx_valid or on entry to HUNT_HI.
  - When idle_cnt==TIMEOUT_CYCLES-1 and no rx_valid arrives: go to HUNT_HI and pulse frame_err.
  - An rx_valid in that same cycle is accepted normally; the byte wins and no timeout occurs.
- Abort
  - cs_abort=1 forces HUNT_HI, and takes priority over rx_valid in the same cycle (the byte is dropped).
  - frame_err pulses only if the state was SYNC_LO or COLLECT.
- Invariants
  - frame_out is never partially updated.
  - The shadow register is not cleared between frames; only complete frames are committed.
- Widths
  - byte_idx is $clog2(PAYLOAD_BYTES) bits.
  - idle_cnt is $clog2(TIMEOUT_CYCLES) bits and saturates (cannot wrap) because the timeout fires first.

Decomposition:
- Shared package coeff_frame_pkg contains:
  - SYNC_WORD
  - PAYLOAD_BYTES
  - FRAME_BITS (336)
  - DEFAULT_FRAME constant
  - Q2.14 unity constant 16'h4000
  - assembler state enum (HUNT_HI, SYNC_LO, COLLECT)
- The downstream extractor uses the same FRAME_BITS.
- Timeout logic lives in one natural sub-module, frame_idle_timer: inputs clk, reset, enable, kick; output expired.
- Everything else stays in the top module.

Test Plan:
1. Reset, no input: frame_out==DEFAULT_FRAME (bits [239:224]=16'h4000, [223:160]=0), frame_valid=0, busy=0.
2. Send AA 55 then bytes 0x01..0x28 back-to-back: one frame_valid pulse the cycle after byte 0x28; frame_out[319:312]=8'h01, [7:0]=8'h28, [335:320]=16'hAA55.
3. Sync edge cases:
   - Send 12 AA AA 55 plus 40 bytes: frame commits (AA repeat handled).
   - Send AA 12 55 plus 40 bytes: no commit, frame_out unchanged, no frame_err.
4. Timeout, with TIMEOUT_CYCLES=16:
   - Send AA 55 and 10 bytes, then idle 16 cycles: frame_err pulses once, busy drops, frame_out unchanged.
   - A byte strobed on idle cycle 16 instead: no error.
5. Abort: cs_abort during byte 20, with rx_valid high in the same cycle: byte dropped, frame_err=1, state HUNT_HI; the next full frame commits correctly.
6. Reset asserted mid-COLLECT after one good frame: frame_out returns to DEFAULT_FRAME the next cycle, with no frame_valid.

Source files
------------

// File: rtl/coeff_frame_pkg.sv
// Shared definitions for the coefficient frame path: sync word, frame
// geometry, the unity-gain default frame and the assembler state encoding.
package coeff_frame_pkg;

  localparam int unsigned PAYLOAD_BYTES = 40;
  localparam int unsigned PAYLOAD_BITS  = 8 * PAYLOAD_BYTES;
  localparam int unsigned FRAME_BITS    = 16 + PAYLOAD_BITS;
  localparam int unsigned BYTE_IDX_W    = $clog2(PAYLOAD_BYTES);

  localparam logic [15:0] SYNC_WORD  = 16'hAA55;
  localparam logic [15:0] Q214_UNITY = 16'h4000;

  // One band: unity gain followed by four zero coefficients.
  localparam logic [79:0] UNITY_BAND = {Q214_UNITY, 64'h0};

  // Sync word, five zero ADC words, then three unity pass-through bands.
  localparam logic [FRAME_BITS-1:0] DEFAULT_FRAME =
    {SYNC_WORD, 80'h0, UNITY_BAND, UNITY_BAND, UNITY_BAND};

  localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);
  localparam logic [BYTE_IDX_W-1:0] IDX_LAST = BYTE_IDX_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT_HI = 2'd0,
    SYNC_LO = 2'd1,
    COLLECT = 2'd2
  } asm_state_e;

  // Bit position of the LSB of payload byte idx; byte 0 sits at the MSB end.
  function automatic int unsigned payload_lsb(input logic [BYTE_IDX_W-1:0] idx);
    return PAYLOAD_BITS - 32'd8 - (32'd8 * int'(idx));
  endfunction

endpackage

// File: rtl/coeff_frame_assembler_timer.sv
// Inter-byte idle timer: counts idle cycles while enabled, restarts on every
// kick, and flags expiry on the last allowed idle cycle without a kick.
module frame_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] idle_cnt_q;
  logic [CNT_W-1:0] idle_cnt_d;

  // Next count: clear when idle-tracking is off or a byte arrives, saturate at the limit.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!enable || kick) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != LAST_CNT) begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign expired = enable && !kick && (idle_cnt_q == LAST_CNT);

endmodule

// File: rtl/coeff_frame_assembler.sv
// Hunts for the sync word in the SPI byte stream, gathers the payload into a
// shadow register and commits whole frames to a double-buffered output.
module coeff_frame_assembler
  import coeff_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic                  cs_abort,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  asm_state_e              state_q, state_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    busy_q;
  logic                    timer_en_s;
  logic                    expired_s;

  assign timer_en_s = (state_q != HUNT_HI);

  frame_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en_s),
    .kick   (rx_valid),
    .expired(expired_s)
  );

  // Sync hunt, payload collection and commit decisions; abort outranks a byte, a byte outranks timeout.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    case (state_q)
      HUNT_HI: begin
        if (cs_abort) begin
          state_d = HUNT_HI;
        end else if (rx_valid && (rx_byte == SYNC_WORD[15:8])) begin
          state_d = SYNC_LO;
        end else begin
          state_d = HUNT_HI;
        end
      end
      SYNC_LO: begin
        if (cs_abort) begin
          state_d     = HUNT_HI;
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          if (rx_byte == SYNC_WORD[7:0]) begin
            state_d    = COLLECT;
            byte_idx_d = '0;
          end else if (rx_byte == SYNC_WORD[15:8]) begin
            state_d = SYNC_LO;
          end else begin
            state_d = HUNT_HI;
          end
        end else if (expired_s) begin
          state_d     = HUNT_HI;
          frame_err_d = 1'b1;
        end else begin
          state_d = SYNC_LO;
        end
      end
      COLLECT: begin
        if (cs_abort) begin
          state_d     = HUNT_HI;
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          shadow_d[payload_lsb(byte_idx_q) +: 8] = rx_byte;
          if (byte_idx_q == IDX_LAST) begin
            frame_d       = {SYNC_WORD, shadow_q[PAYLOAD_BITS-1:8], rx_byte};
            frame_valid_d = 1'b1;
            byte_idx_d    = '0;
            state_d       = HUNT_HI;
          end else begin
            byte_idx_d = byte_idx_q + IDX_ONE;
            state_d    = COLLECT;
          end
        end else if (expired_s) begin
          state_d     = HUNT_HI;
          frame_err_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = HUNT_HI;
      end
    endcase
  end

  // State, shadow and registered outputs; reset restores the unity default frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT_HI;
      byte_idx_q    <= '0;
      shadow_q      <= '0;
      frame_q       <= DEFAULT_FRAME;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= (state_d != HUNT_HI);
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_coeff_frame_assembler.sv
// Directed self-checking bench for coeff_frame_assembler (timeout shortened to 16).
module tb_coeff_frame_assembler;

  localparam logic [335:0] EXP_DEFAULT =
    {16'hAA55, 80'h0, 16'h4000, 64'h0, 16'h4000, 64'h0, 16'h4000, 64'h0};

  logic         clk;
  logic         reset;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         cs_abort;
  logic [335:0] frame_out;
  logic         frame_valid;
  logic         frame_err;
  logic         busy;

  int n_cmp;
  int n_bad;
  int fv_seen;
  int fe_seen;
  logic [7:0]   pl [40];
  logic [335:0] held;

  coeff_frame_assembler #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .cs_abort   (cs_abort),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_seen++;
    if (frame_err === 1'b1) fe_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pl(input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(pl[i]);
  endtask

  task automatic fill_pl(input logic [7:0] base);
    for (int i = 0; i < 40; i++) pl[i] = base + 8'(i);
  endtask

  function automatic logic [335:0] build_frame();
    logic [335:0] f;
    f[335:320] = 16'hAA55;
    for (int i = 0; i < 40; i++) f[319-8*i -: 8] = pl[i];
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; cs_abort = 1'b0; rx_byte = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (frame_out !== EXP_DEFAULT) begin n_bad++; $display("FAIL reset_frame: got %h expected %h", frame_out, EXP_DEFAULT); end
    n_cmp++; if (frame_out[239:224] !== 16'h4000) begin n_bad++; $display("FAIL reset_unity: got %h expected 4000", frame_out[239:224]); end
    n_cmp++; if (frame_out[223:160] !== 64'h0) begin n_bad++; $display("FAIL reset_zero_coeffs: got %h expected 0", frame_out[223:160]); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_frame();
    int fv0;
    fv0 = fv_seen;
    fill_pl(8'h01);
    send_byte(8'hAA);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_sync: got %b expected 1", busy); end
    send_byte(8'h55);
    send_pl(0, 38);
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_fv: got %b expected 0", frame_valid); end
    send_pl(39, 39);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_fv: got %b expected 1", frame_valid); end
    n_cmp++; if (frame_out[319:312] !== 8'h01) begin n_bad++; $display("FAIL basic_first_byte: got %h expected 01", frame_out[319:312]); end
    n_cmp++; if (frame_out[7:0] !== 8'h28) begin n_bad++; $display("FAIL basic_last_byte: got %h expected 28", frame_out[7:0]); end
    n_cmp++; if (frame_out[335:320] !== 16'hAA55) begin n_bad++; $display("FAIL basic_sync: got %h expected aa55", frame_out[335:320]); end
    n_cmp++; if (frame_out !== build_frame()) begin n_bad++; $display("FAIL basic_frame: got %h expected %h", frame_out, build_frame()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_fv_pulse: got %b expected 0", frame_valid); end
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_bad++; $display("FAIL basic_fv_count: got %0d expected 1", fv_seen - fv0); end
  endtask

  task automatic test_back_to_back();
    int fv0;
    logic [335:0] first;
    fv0 = fv_seen;
    fill_pl(8'h90);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 39);
    first = build_frame();
    n_cmp++; if (frame_out !== first) begin n_bad++; $display("FAIL b2b_first: got %h expected %h", frame_out, first); end
    fill_pl(8'h20);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 39);
    n_cmp++; if (frame_out !== build_frame()) begin n_bad++; $display("FAIL b2b_second: got %h expected %h", frame_out, build_frame()); end
    tick();
    n_cmp++; if (fv_seen - fv0 !== 2) begin n_bad++; $display("FAIL b2b_fv_count: got %0d expected 2", fv_seen - fv0); end
  endtask

  task automatic test_sync_edges();
    int fv0;
    int fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    fill_pl(8'h50);
    send_byte(8'h12); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_pl(0, 39);
    n_cmp++; if (frame_out !== build_frame()) begin n_bad++; $display("FAIL sync_aa_repeat: got %h expected %h", frame_out, build_frame()); end
    tick();
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_bad++; $display("FAIL sync_aa_repeat_count: got %0d expected 1", fv_seen - fv0); end
    held = frame_out;
    fv0 = fv_seen;
    fill_pl(8'h80);
    send_byte(8'hAA); send_byte(8'h12); send_byte(8'h55);
    send_pl(0, 39);
    tick();
    n_cmp++; if (fv_seen - fv0 !== 0) begin n_bad++; $display("FAIL sync_broken_commit: got %0d expected 0", fv_seen - fv0); end
    n_cmp++; if (frame_out !== held) begin n_bad++; $display("FAIL sync_broken_frame: got %h expected %h", frame_out, held); end
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_bad++; $display("FAIL sync_broken_err: got %0d expected 0", fe_seen - fe0); end
  endtask

  task automatic test_timeout();
    int fe0;
    int fv0;
    held = frame_out;
    fe0 = fe_seen;
    fill_pl(8'h10);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 9);
    repeat (15) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tmo_busy_before: got %b expected 1", busy); end
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_bad++; $display("FAIL tmo_early_err: got %0d expected 0", fe_seen - fe0); end
    tick();
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_after: got %b expected 0", busy); end
    tick();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_pulse: got %b expected 0", frame_err); end
    n_cmp++; if (fe_seen - fe0 !== 1) begin n_bad++; $display("FAIL tmo_err_count: got %0d expected 1", fe_seen - fe0); end
    n_cmp++; if (frame_out !== held) begin n_bad++; $display("FAIL tmo_frame_kept: got %h expected %h", frame_out, held); end
    // A byte on idle cycle 16 keeps the frame alive.
    fe0 = fe_seen; fv0 = fv_seen;
    fill_pl(8'h30);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 9);
    repeat (15) tick();
    send_pl(10, 10);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL tmo_save_err: got %b expected 0", frame_err); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tmo_save_busy: got %b expected 1", busy); end
    send_pl(11, 39);
    n_cmp++; if (frame_out !== build_frame()) begin n_bad++; $display("FAIL tmo_save_frame: got %h expected %h", frame_out, build_frame()); end
    tick();
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_bad++; $display("FAIL tmo_save_err_count: got %0d expected 0", fe_seen - fe0); end
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_bad++; $display("FAIL tmo_save_fv_count: got %0d expected 1", fv_seen - fv0); end
  endtask

  task automatic test_abort();
    held = frame_out;
    fill_pl(8'hC0);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 18);
    rx_byte = pl[19]; rx_valid = 1'b1; cs_abort = 1'b1;
    tick();
    rx_valid = 1'b0; cs_abort = 1'b0;
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL abort_err: got %b expected 1", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (frame_out !== held) begin n_bad++; $display("FAIL abort_frame_kept: got %h expected %h", frame_out, held); end
    fill_pl(8'hE0);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 39);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL abort_next_fv: got %b expected 1", frame_valid); end
    n_cmp++; if (frame_out !== build_frame()) begin n_bad++; $display("FAIL abort_next_frame: got %h expected %h", frame_out, build_frame()); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    fv0 = fv_seen;
    fill_pl(8'h70);
    send_byte(8'hAA); send_byte(8'h55); send_pl(0, 4);
    reset = 1'b1;
    tick();
    n_cmp++; if (frame_out !== EXP_DEFAULT) begin n_bad++; $display("FAIL rstmid_frame: got %h expected %h", frame_out, EXP_DEFAULT); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_fv: got %b expected 0", frame_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
    n_cmp++; if (fv_seen - fv0 !== 0) begin n_bad++; $display("FAIL rstmid_fv_count: got %0d expected 0", fv_seen - fv0); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; fv_seen = 0; fe_seen = 0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_sync_edges();
    test_timeout();
    test_abort();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
